// File: rtl/wb_arbiter.sv
// Writeback arbiter: grants up to ewd live FU results per cycle with round-robin priority and drops squashed ones.
// Latency: 1 cycle, from a claimed FU head to the registered wb lane.
// Backpressure: none; claim is combinational and the wb bus always accepts ewd lanes.
//
// Ports:
//   clk      clock, all state updates on posedge
//   rst      synchronous active-low reset (0 = reset)
//   redir    redirect bundle; opid[15] marks it valid, topid is the oldest in-flight op
//   fu_resp  [nfu] FU head results, valid = opid[15]
//   claim    [nfu] FU pops its head this cycle (granted or squashed)
//   wb       [ewd] registered writeback lanes, valid = opid[15], packed from lane 0
//   wb_cnt   registered number of valid wb lanes

package wb_arbiter_pkg;

    typedef struct packed {
        logic [15:0] opid;
        logic [15:0] topid;
    } red_bundle_t;

    typedef struct packed {
        logic [15:0] opid;
        logic [7:0]  brid;
        logic [7:0]  ldid;
        logic [7:0]  stid;
        logic [31:0] pc;
        logic [31:0] npc;
        logic [7:0]  prda;
        logic [63:0] prdv;
    } exe_bundle_t;

endpackage

module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int nfu  = 4,
    parameter int ewd  = 2,
    parameter int opsz = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  red_bundle_t           redir,
    input  exe_bundle_t           fu_resp [nfu],
    output logic [nfu-1:0]        claim,
    output exe_bundle_t           wb      [ewd],
    output logic [$clog2(ewd):0]  wb_cnt
);

    localparam int AW = $clog2(opsz);
    localparam int PW = (nfu > 1) ? $clog2(nfu) : 1;
    localparam int CW = $clog2(ewd) + 1;

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] rr_nxt;

    logic [nfu-1:0] valid;
    logic [nfu-1:0] dead;
    logic [nfu-1:0] live;
    logic [nfu-1:0] granted;

    logic [AW-1:0] red_age;
    logic [AW-1:0] fu_age [nfu];

    exe_bundle_t wb_nxt [ewd];
    int          idx;
    int          cnt;
    int          last;

    // Ages are measured from the oldest in-flight op so that ID wrap-around
    // compares correctly. An op is younger than the redirect (and dies) when its
    // age is strictly greater; the redirect's own op therefore survives.
    assign red_age = redir.opid[AW-1:0] - redir.topid[AW-1:0];

    always_comb begin
        for (int i = 0; i < nfu; i++) begin
            fu_age[i] = fu_resp[i].opid[AW-1:0] - redir.topid[AW-1:0];
            valid[i]  = fu_resp[i].opid[15];
            dead[i]   = redir.opid[15] & valid[i] &
                        ({1'b0, fu_age[i]} > {1'b0, red_age});
        end
    end

    assign live = valid & ~dead;

    // Scan from rr_ptr; the k-th live FU met goes to lane k until lanes run out.
    always_comb begin
        granted = '0;
        cnt     = 0;
        last    = 0;
        idx     = 0;
        for (int k = 0; k < ewd; k++) begin
            wb_nxt[k] = '0;
        end
        for (int j = 0; j < nfu; j++) begin
            idx = int'(rr_ptr) + j;
            if (idx >= nfu) begin
                idx = idx - nfu;
            end
            if (live[idx] && (cnt < ewd)) begin
                granted[idx] = 1'b1;
                wb_nxt[cnt]  = fu_resp[idx];
                cnt          = cnt + 1;
                last         = idx;
            end
        end
    end

    // Priority moves just past the last winner so a busy neighbour cannot starve it.
    assign rr_nxt = (last + 1 >= nfu) ? '0 : PW'(last + 1);

    // Dead heads are popped alongside the winners so they never block a port.
    assign claim = rst ? (dead | granted) : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr <= '0;
            wb_cnt <= '0;
            for (int k = 0; k < ewd; k++) begin
                wb[k] <= '0;
            end
        end else begin
            wb_cnt <= CW'(cnt);
            for (int k = 0; k < ewd; k++) begin
                wb[k] <= wb_nxt[k];
            end
            if (cnt != 0) begin
                rr_ptr <= rr_nxt;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with nfu=4, ewd=2, opsz=64.
// Inputs change 1 ns after posedge; claim is sampled at negedge, wb 1 ns after the next posedge.
// The DUT has no backpressure so every step is a fixed single cycle.

module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    red_bundle_t    redir;
    exe_bundle_t    fu_resp [4];
    logic [3:0]     claim;
    exe_bundle_t    wb      [2];
    logic [1:0]     wb_cnt;

    int errors = 0;
    int checks = 0;

    exe_bundle_t exp_l0;
    exe_bundle_t exp_l1;
    exe_bundle_t zero_b;

    wb_arbiter #(.nfu(4), .ewd(2), .opsz(64)) dut (
        .clk     (clk),
        .rst     (rst),
        .redir   (redir),
        .fu_resp (fu_resp),
        .claim   (claim),
        .wb      (wb),
        .wb_cnt  (wb_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Distinct payload per port and op so lane swaps or stale data show up.
    function automatic exe_bundle_t mk(input int port, input logic [15:0] op);
        exe_bundle_t b;
        b.opid = op;
        b.brid = 8'(port * 3 + 1);
        b.ldid = 8'(op[7:0] ^ 8'h5a);
        b.stid = 8'(port + 8'h40);
        b.pc   = 32'h1000_0000 + 32'(port) * 32'h100 + 32'(op[7:0]);
        b.npc  = 32'h2000_0000 + 32'(op[7:0]) * 4;
        b.prda = 8'(port * 16) + op[7:0];
        b.prdv = {32'(port), 16'hbeef, op};
        return b;
    endfunction

    task automatic clear_ports();
        for (int i = 0; i < 4; i++) fu_resp[i] = '0;
    endtask

    // Advance to negedge for claim sampling.
    task automatic to_neg();
        @(negedge clk);
    endtask

    // Advance past the next posedge for wb sampling and new stimulus.
    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    initial begin
        zero_b = '0;
        redir  = '0;
        clear_ports();
        rst = 1'b0;

        // Reset with every port valid: nothing claimed, outputs cleared.
        for (int i = 0; i < 4; i++) fu_resp[i] = mk(i, 16'h8000 | 16'(i));
        to_neg();
        check("rst_claim", 256'(claim), 256'(4'b0000));
        to_pos();
        check("rst_wbcnt", 256'(wb_cnt), 256'(2'd0));
        check("rst_wb0", 256'(wb[0]), 256'(zero_b));
        check("rst_wb1", 256'(wb[1]), 256'(zero_b));

        // Fairness: all four busy, pairs alternate 0011 / 1100.
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < 4; i++) fu_resp[i] = mk(i, 16'h8000 | 16'(c * 4 + i));
            to_neg();
            check("fair_claim", 256'(claim), 256'((c % 2 == 0) ? 4'b0011 : 4'b1100));
            exp_l0 = (c % 2 == 0) ? fu_resp[0] : fu_resp[2];
            exp_l1 = (c % 2 == 0) ? fu_resp[1] : fu_resp[3];
            to_pos();
            check("fair_cnt", 256'(wb_cnt), 256'(2'd2));
            check("fair_wb0", 256'(wb[0]), 256'(exp_l0));
            check("fair_wb1", 256'(wb[1]), 256'(exp_l1));
        end

        // Packing: rr_ptr is now 2, only ports 1 and 3 valid -> port3 in lane 0.
        clear_ports();
        fu_resp[1] = mk(1, 16'h8000 | 16'd33);
        fu_resp[3] = mk(3, 16'h8000 | 16'd35);
        to_neg();
        check("pack_claim", 256'(claim), 256'(4'b1010));
        exp_l0 = fu_resp[3];
        exp_l1 = fu_resp[1];
        to_pos();
        check("pack_cnt", 256'(wb_cnt), 256'(2'd2));
        check("pack_wb0", 256'(wb[0]), 256'(exp_l0));
        check("pack_wb1", 256'(wb[1]), 256'(exp_l1));

        // Squash: redirect at 20 from top 10; op 15 survives, op 25 is dropped.
        // rr_ptr is 2 here, so the scan order is 2,3,0,1.
        clear_ports();
        redir.topid = 16'd10;
        redir.opid  = 16'h8000 | 16'd20;
        fu_resp[0]  = mk(0, 16'h8000 | 16'd15);
        fu_resp[1]  = mk(1, 16'h8000 | 16'd25);
        to_neg();
        check("sq_claim", 256'(claim), 256'(4'b0011));
        exp_l0 = fu_resp[0];
        to_pos();
        check("sq_cnt", 256'(wb_cnt), 256'(2'd1));
        check("sq_wb0", 256'(wb[0]), 256'(exp_l0));
        check("sq_wb1", 256'(wb[1]), 256'(zero_b));

        // Redirect's own opid is never killed (rr_ptr now 1).
        clear_ports();
        fu_resp[2] = mk(2, 16'h8000 | 16'd20);
        to_neg();
        check("own_claim", 256'(claim), 256'(4'b0100));
        exp_l0 = fu_resp[2];
        to_pos();
        check("own_cnt", 256'(wb_cnt), 256'(2'd1));
        check("own_wb0", 256'(wb[0]), 256'(exp_l0));

        // Wrap-around: top 60, redirect 62; op 1 is younger (killed), op 61 older.
        // rr_ptr is 3 here.
        clear_ports();
        redir.topid = 16'd60;
        redir.opid  = 16'h8000 | 16'd62;
        fu_resp[2]  = mk(2, 16'h8000 | 16'd1);
        fu_resp[3]  = mk(3, 16'h8000 | 16'd61);
        to_neg();
        check("wrap_claim", 256'(claim), 256'(4'b1100));
        exp_l0 = fu_resp[3];
        to_pos();
        check("wrap_cnt", 256'(wb_cnt), 256'(2'd1));
        check("wrap_wb0", 256'(wb[0]), 256'(exp_l0));
        check("wrap_wb1", 256'(wb[1]), 256'(zero_b));

        // All inputs dead: claimed, nothing written, rr_ptr holds at 0.
        clear_ports();
        fu_resp[1] = mk(1, 16'h8000 | 16'd2);
        fu_resp[2] = mk(2, 16'h8000 | 16'd5);
        to_neg();
        check("dead_claim", 256'(claim), 256'(4'b0110));
        to_pos();
        check("dead_cnt", 256'(wb_cnt), 256'(2'd0));
        check("dead_wb0", 256'(wb[0]), 256'(zero_b));

        // rr_ptr held at 0 -> next full-load grant is ports 0,1.
        redir = '0;
        for (int i = 0; i < 4; i++) fu_resp[i] = mk(i, 16'h8000 | 16'(40 + i));
        to_neg();
        check("hold_claim", 256'(claim), 256'(4'b0011));
        to_pos();
        check("hold_cnt", 256'(wb_cnt), 256'(2'd2));

        // Reset mid-stream with rr_ptr at 2 and wb_cnt=2.
        rst = 1'b0;
        for (int i = 0; i < 4; i++) fu_resp[i] = mk(i, 16'h8000 | 16'(50 + i));
        to_neg();
        check("mrst_claim", 256'(claim), 256'(4'b0000));
        to_pos();
        check("mrst_cnt", 256'(wb_cnt), 256'(2'd0));
        check("mrst_wb1", 256'(wb[1]), 256'(zero_b));
        rst = 1'b1;
        to_neg();
        check("post_claim", 256'(claim), 256'(4'b0011));
        exp_l0 = fu_resp[0];
        exp_l1 = fu_resp[1];
        to_pos();
        check("post_wb0", 256'(wb[0]), 256'(exp_l0));
        check("post_wb1", 256'(wb[1]), 256'(exp_l1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
